// File: rtl/pc_update_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_update_unit
//  Purpose  : Program-counter sequencer. Holds a 30-bit word address and picks
//             the next one each cycle (halt, stall, jump, taken branch or
//             sequential). After any non-sequential update it raises a
//             one-cycle redirect pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_update_unit #(
  parameter logic [29:0] RESET_PC = 30'h0010_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] imm16_ext,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [25:0] target26,
  input  logic        stall,
  input  logic        halt,
  output logic [29:0] pc,
  output logic [29:0] pc_plus1,
  output logic        running,
  output logic        redirect
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;

  // Outputs: the incrementer is purely combinational so it follows pc in the same cycle
  always_comb begin
    pc       = pc_q;
    pc_plus1 = pc_q + 30'd1;
    running  = (state_q == ST_RUN);
    redirect = redirect_q;
  end

  // Next-state / next-PC selection; priority is halt > stall > jump > taken branch > sequential
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (stall) begin
          // Held PC; the stalled jump/branch is dropped, not queued
          pc_d = pc_q;
        end else if (jump) begin
          // Jump keeps the 4 region bits of the incremented PC
          pc_d       = {pc_plus1[29:26], target26};
          redirect_d = 1'b1;
        end else if (branch && zero) begin
          pc_d       = pc_plus1 + imm16_ext;
          redirect_d = 1'b1;
        end else begin
          pc_d = pc_plus1;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        // Unused encoding: fall back to a clean start
        state_d = ST_INIT;
      end
    endcase
  end

  // State registers with synchronous active-low reset that overrides every state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_update_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_update_unit
//  Purpose  : Self-checking bench for pc_update_unit. Expected pc / redirect /
//             running triples are queued when stimulus is applied and popped
//             after the following rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_update_unit;

  localparam logic [29:0] C_RESET_PC = 30'h0010_0000;

  typedef struct {
    logic [29:0] pc;
    logic        redir;
    logic        run;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [29:0] imm16_ext;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [25:0] target26;
  logic        stall;
  logic        halt;
  logic [29:0] pc;
  logic [29:0] pc_plus1;
  logic        running;
  logic        redirect;

  exp_t        sb[$];
  exp_t        e;
  logic [29:0] cur_pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  pc_update_unit #(.RESET_PC(C_RESET_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imm16_ext (imm16_ext),
    .branch    (branch),
    .zero      (zero),
    .jump      (jump),
    .target26  (target26),
    .stall     (stall),
    .halt      (halt),
    .pc        (pc),
    .pc_plus1  (pc_plus1),
    .running   (running),
    .redirect  (redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imm16_ext = '0; branch = 0; zero = 0; jump = 0;
    target26 = '0; stall = 0; halt = 0;
  endtask

  task automatic push_exp(input logic [29:0] p, input logic r, input logic run);
    exp_t x;
    x.pc = p; x.redir = r; x.run = run;
    sb.push_back(x);
    cur_pc = p;
  endtask

  // Move the PC to an arbitrary address with a taken branch (DUT must be in RUN)
  task automatic goto_pc(input logic [29:0] target);
    idle_inputs();
    branch = 1; zero = 1;
    imm16_ext = target - (cur_pc + 30'd1);
    tick();
    cur_pc = target;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    push_exp(C_RESET_PC, 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
               pc, redirect, running, e.pc, e.redir, e.run);
    end
    n_checks++;
    if (pc_plus1 !== 30'h0010_0001) begin
      n_fail++;
      $display("FAIL reset_pc_plus1: got %h expected %h", pc_plus1, 30'h0010_0001);
    end
    // A low pulse on rst_n between edges must not reach the flops
    rst_n = 1;
    #2 rst_n = 0;
    #2 rst_n = 1;
    push_exp(C_RESET_PC, 1'b0, 1'b1);     // INIT -> RUN, PC held
    push_exp(30'h0010_0001, 1'b0, 1'b1);
    push_exp(30'h0010_0002, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
        n_fail++;
        $display("FAIL reset_seq[%0d]: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
                 i, pc, redirect, running, e.pc, e.redir, e.run);
      end
    end
  endtask

  task automatic test_branch();
    // Taken backward branch, then one sequential cycle to see redirect drop
    goto_pc(30'h0010_0005);
    branch = 1; zero = 1; imm16_ext = 30'h3FFF_FFFC;
    push_exp(30'h0010_0002, 1'b1, 1'b1);
    tick();
    idle_inputs();
    push_exp(30'h0010_0003, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
        n_fail++;
        $display("FAIL branch_taken[%0d]: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
                 i, pc, redirect, running, e.pc, e.redir, e.run);
      end
      if (i == 0) tick();
    end
    // Not taken: sequential
    goto_pc(30'h0010_0005);
    tick();  // let the goto redirect pulse clear
    cur_pc = 30'h0010_0006;
    goto_pc(30'h0010_0005);
    branch = 1; zero = 0; imm16_ext = 30'h3FFF_FFFC;
    push_exp(30'h0010_0006, 1'b0, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
      n_fail++;
      $display("FAIL branch_not_taken: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
               pc, redirect, running, e.pc, e.redir, e.run);
    end
    // Backward branch wrapping below zero: pc=1, pc+1=2, 2-4 = 0x3FFFFFFE
    goto_pc(30'h0000_0001);
    branch = 1; zero = 1; imm16_ext = 30'h3FFF_FFFC;
    push_exp(30'h3FFF_FFFE, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
      n_fail++;
      $display("FAIL branch_wrap: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
               pc, redirect, running, e.pc, e.redir, e.run);
    end
    idle_inputs();
  endtask

  task automatic test_jump();
    goto_pc(30'h2000_0010);
    jump = 1; branch = 1; zero = 1; imm16_ext = 30'h0000_0100; target26 = 26'h000_0040;
    push_exp(30'h2000_0040, 1'b1, 1'b1);
    tick();
    // Back-to-back jump from 0x03FFFFFF: pc+1 crosses into region 1
    goto_pc(30'h03FF_FFFF);
    cur_pc = 30'h2000_0040;
    jump = 1; target26 = 26'h123_4567;
    push_exp(30'h0523_4567, 1'b1, 1'b1);
    sb.delete(1);
    e = sb.pop_front();
    n_checks++;
    // first expectation was sampled before the goto edge; compare against stored value
    if (e.pc !== 30'h2000_0040) begin
      n_fail++;
      $display("FAIL jump_sb_order: got %h expected %h", e.pc, 30'h2000_0040);
    end
    push_exp(30'h0523_4567, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
      n_fail++;
      $display("FAIL jump_region: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
               pc, redirect, running, e.pc, e.redir, e.run);
    end
    // Jump immediately followed by a taken branch: redirect stays high
    jump = 0; branch = 1; zero = 1; imm16_ext = 30'h0000_0010;
    push_exp(30'h0523_4578, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
      n_fail++;
      $display("FAIL back_to_back: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
               pc, redirect, running, e.pc, e.redir, e.run);
    end
    idle_inputs();
  endtask

  task automatic test_jump_priority();
    goto_pc(30'h2000_0010);
    jump = 1; branch = 1; zero = 1; imm16_ext = 30'h0000_0100; target26 = 26'h000_0040;
    push_exp(30'h2000_0040, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
      n_fail++;
      $display("FAIL jump_priority: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
               pc, redirect, running, e.pc, e.redir, e.run);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    goto_pc(30'h0010_0003);
    stall = 1; jump = 1; target26 = 26'h000_0000; branch = 1; zero = 1; imm16_ext = 30'h10;
    push_exp(30'h0010_0003, 1'b0, 1'b1);
    push_exp(30'h0010_0003, 1'b0, 1'b1);
    push_exp(30'h0010_0004, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) idle_inputs();
      tick();
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
        n_fail++;
        $display("FAIL stall[%0d]: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
                 i, pc, redirect, running, e.pc, e.redir, e.run);
      end
    end
  endtask

  task automatic test_wrap_halt();
    goto_pc(30'h3FFF_FFFF);
    n_checks++;
    if (pc_plus1 !== 30'h0000_0000) begin
      n_fail++;
      $display("FAIL pc_plus1_wrap: got %h expected %h", pc_plus1, 30'h0000_0000);
    end
    push_exp(30'h0000_0000, 1'b0, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
      n_fail++;
      $display("FAIL seq_wrap: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
               pc, redirect, running, e.pc, e.redir, e.run);
    end
    for (int i = 0; i < 10; i++) begin
      halt      = (i == 0) ? 1'b1 : 1'(($urandom) & 1);
      jump      = 1'($urandom);
      branch    = 1'($urandom);
      zero      = 1'($urandom);
      stall     = 1'($urandom);
      target26  = 26'($urandom);
      imm16_ext = 30'($urandom);
      push_exp(30'h0000_0000, 1'b0, 1'b0);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
        n_fail++;
        $display("FAIL halted[%0d]: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
                 i, pc, redirect, running, e.pc, e.redir, e.run);
      end
    end
    idle_inputs();
  endtask

  task automatic test_halt_reset();
    rst_n = 0;
    jump = 1; target26 = 26'h3FF_FFFF;
    push_exp(C_RESET_PC, 1'b0, 1'b0);
    tick();
    rst_n = 1;
    idle_inputs();
    push_exp(C_RESET_PC, 1'b0, 1'b1);
    push_exp(30'h0010_0001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
        n_fail++;
        $display("FAIL halt_reset[%0d]: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
                 i, pc, redirect, running, e.pc, e.redir, e.run);
      end
      if (i < 2) tick();
    end
    // Reset landing while a redirect pulse is high clears it
    jump = 1; target26 = 26'h000_0123;
    tick();
    idle_inputs();
    rst_n = 0;
    push_exp(C_RESET_PC, 1'b0, 1'b0);
    tick();
    rst_n = 1;
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || redirect !== e.redir || running !== e.run) begin
      n_fail++;
      $display("FAIL reset_mid_redirect: pc=%h redir=%b run=%b expected pc=%h redir=%b run=%b",
               pc, redirect, running, e.pc, e.redir, e.run);
    end
  endtask

  initial begin
    rst_n  = 0;
    cur_pc = C_RESET_PC;
    idle_inputs();
    test_reset();
    test_branch();
    test_jump_priority();
    test_stall();
    test_jump();
    test_wrap_halt();
    test_halt_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
